// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and address helpers for the load/store unit.
// Misalignment handling depends on LSU_MISALIGN_TRAP_EN (see load_store_unit).
package lsu_pkg;

    localparam int unsigned WORD_OFFSET_W = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } lsu_state_e;

    // Size 2'b11 is an alias for a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [WORD_OFFSET_W-1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != '0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WORD_OFFSET_W-1:0] force_align(input logic [1:0] size,
                                                             input logic [WORD_OFFSET_W-1:0] off);
        case (size)
            SZ_HALF: return {off[1], 1'b0};
            SZ_WORD: return '0;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and read-modify-write lane merge for stores.
// Purely combinational; size is expected to be already normalised.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]               size,
    input  logic                     sign_ext,
    input  logic [WORD_OFFSET_W-1:0] offset,
    input  logic [31:0]              rdata,
    input  logic [31:0]              wdata,
    output logic [31:0]              load_data,
    output logic [31:0]              store_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;

    assign byte_pos = {offset, 3'b000};
    assign half_pos = {offset[1], 4'b0000};

    always_comb begin
        byte_v     = rdata[byte_pos +: 8];
        half_v     = rdata[half_pos +: 16];
        load_data  = rdata;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_v[7]}}, byte_v};
                store_data = rdata;
                store_data[byte_pos +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & half_v[15]}}, half_v};
                store_data = rdata;
                store_data[half_pos +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time through IDLE -> RD/WR -> RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses with rsp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    lsu_state_e               state_q;
    logic                     write_q;
    logic                     signed_q;
    logic [1:0]               size_q;
    logic [WORD_OFFSET_W-1:0] offset_q;
    logic [31:0]              wdata_q;

    logic [1:0]               req_size_n;
    logic                     req_mis;
    logic [WORD_OFFSET_W-1:0] req_off;
    logic [31:0]              load_data;
    logic [31:0]              store_data;

    assign req_size_n = norm_size(req_size);
    assign req_ready  = (state_q == StIdle);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = is_misaligned(req_size_n, req_addr[WORD_OFFSET_W-1:0]);
    assign req_off = req_addr[WORD_OFFSET_W-1:0];
`else
    assign req_mis = 1'b0;
    assign req_off = force_align(req_size_n, req_addr[WORD_OFFSET_W-1:0]);
`endif

    // Aligner works directly on the memory word during the RD cycle.
    lsu_align u_align (
        .size       (size_q),
        .sign_ext   (signed_q),
        .offset     (offset_q),
        .rdata      (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= SZ_BYTE;
            offset_q       <= '0;
            wdata_q        <= '0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        signed_q    <= req_signed;
                        size_q      <= req_size_n;
                        offset_q    <= req_off;
                        wdata_q     <= req_wdata;
                        mem_address <= MEM_ADDR_W'(req_addr[31:WORD_OFFSET_W]);
                        if (req_mis) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (!req_write || req_size_n != SZ_WORD) begin
                            // Loads and sub-word stores both need the current word.
                            state_q <= StRd;
                            MemRead <= 1'b1;
                        end else begin
                            state_q        <= StWr;
                            MemWrite       <= 1'b1;
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                StRd: begin
                    MemRead <= 1'b0;
                    if (write_q) begin
                        state_q        <= StWr;
                        MemWrite       <= 1'b1;
                        mem_write_data <= store_data;
                    end else begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_data  <= load_data;
                    end
                end
                StWr: begin
                    MemWrite  <= 1'b0;
                    state_q   <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    assign mem_read_data = MemRead ? mem[mem_address[5:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (MemWrite) mem[mem_address[5:0]] = mem_write_data;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({pfx, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({pfx, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
        check({pfx, "_rsp_data"}, rsp_data, 32'd0);
        check({pfx, "_memread"}, {31'b0, MemRead}, 32'd0);
        check({pfx, "_memwrite"}, {31'b0, MemWrite}, 32'd0);
        check({pfx, "_mem_address"}, mem_address, 32'd0);
        check({pfx, "_mem_write_data"}, mem_write_data, 32'd0);
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // One complete request: drive, follow the strobes, check the response, release it.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] got);
        int          n, off, lat, reads, writes, exp_lat, exp_reads, exp_writes;
        bit          trap;
        logic [31:0] old, mask, lane_mask, loaded, exp_mem, exp_data;
        n    = nbytes_of(sz);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (int'(a[1:0]) % n) != 0;
`else
        trap = 1'b0;
`endif
        off       = (int'(a[1:0]) / n) * n;
        old       = ref_mem[a[7:2]];
        lane_mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        mask      = lane_mask << (8 * off);
        exp_mem   = (old & ~mask) | ((wd << (8 * off)) & mask);
        loaded    = (old & mask) >> (8 * off);
        if (sg && n < 4 && loaded[8 * n - 1]) loaded = loaded | ~lane_mask;
        exp_data   = (trap || wr) ? 32'h0 : loaded;
        exp_lat    = trap ? 1 : (!wr || n == 4) ? 2 : 3;
        exp_reads  = (!trap && (!wr || n < 4)) ? 1 : 0;
        exp_writes = (!trap && wr) ? 1 : 0;

        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_signed = sg;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);
        lat = 1;
        reads = 0;
        writes = 0;
        while (!rsp_valid && lat < 10) begin
            check("strobe_excl", {31'b0, MemRead & MemWrite}, 32'd0);
            if (MemRead) reads++;
            if (MemWrite) begin
                writes++;
                check("mem_write_data", mem_write_data, exp_mem);
            end
            if (MemRead || MemWrite) check("mem_address", mem_address, a >> 2);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("read_strobes", 32'(reads), 32'(exp_reads));
        check("write_strobes", 32'(writes), 32'(exp_writes));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, trap});
        check("resp_no_strobe", {30'b0, MemRead, MemWrite}, 32'd0);
        got = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rsp_data", rsp_data, exp_data);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("released_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("released_req_ready", {31'b0, req_ready}, 32'd1);
        if (wr && !trap) ref_mem[a[7:2]] = exp_mem;
        check("mem_contents", mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        #1 rst = 1'b0;
        #2 check_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 64; i++) do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 0, got);

        // Word load at byte address 60 reads word 15.
        do_req(1'b1, 2'b10, 1'b0, 32'd60, 32'd65, 0, got);
        do_req(1'b0, 2'b10, 1'b0, 32'd60, 32'd0, 0, got);
        check("word15_load", got, 32'd65);

        // Byte store into the middle of word 10, then signed reload.
        do_req(1'b1, 2'b10, 1'b0, 32'd40, 32'h1122_3344, 0, got);
        do_req(1'b1, 2'b00, 1'b0, 32'd41, 32'h0000_00AB, 0, got);
        check("byte_store_mem", mem[10], 32'h1122_AB44);
        do_req(1'b0, 2'b00, 1'b1, 32'd41, 32'd0, 0, got);
        check("byte_signed_load", got, 32'hFFFF_FFAB);

        do_req(1'b1, 2'b10, 1'b0, 32'd40, 32'h8001_7FFF, 0, got);
        do_req(1'b0, 2'b01, 1'b1, 32'd42, 32'd0, 0, got);
        check("half_signed_load", got, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b0, 32'd42, 32'd0, 0, got);
        check("half_unsigned_load", got, 32'h0000_8001);

        do_req(1'b0, 2'b10, 1'b0, 32'd62, 32'd0, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misaligned_word_load", got, 32'd0);
`else
        check("misaligned_word_load", got, 32'd65);
`endif

        // Response back-pressure.
        do_req(1'b0, 2'b11, 1'b0, 32'd60, 32'd0, 5, got);

        // Reset during the WR cycle of a word store abandons it.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'd40;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wr_cycle_strobe", {31'b0, MemWrite}, 32'd1);
        #1 rst = 1'b0;
        #1 check_reset("midreq_reset");
        @(posedge clk);
        #1;
        check("midreq_mem_unchanged", mem[10], ref_mem[10]);
        check("midreq_no_rsp", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'd0, 0, got);
        check("post_reset_load", got, 32'h8001_7FFF);

        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
                   $urandom_range(0, 2), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 32: width of mem_address (word index).
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have ports MemRead, MemWrite  output  1 each  Data_Memory strobes.
REQ-012 SHALL have port mem_address  output  MEM_ADDR_W  word index = req_addr[31:2], zero-extended or truncated.
REQ-013 SHALL have ports mem_write_data  output  32  and  mem_read_data  input  32; mem_read_data is combinationally valid while MemRead=1.
REQ-014 SHALL have ports rsp_valid  output  1,  rsp_ready  input  1,  rsp_data  output  32,  rsp_err  output  1.

Function
REQ-015 SHALL implement FSM IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-016 On acceptance, SHALL latch write, size, signed, addr, wdata; next state: misaligned (under REQ-028) -> RESP, load or sub-word store -> RD, word store -> WR.
REQ-017 In RD, SHALL assert MemRead=1 for exactly one cycle and capture mem_read_data at the end of that cycle.
REQ-018 From RD, a load SHALL go to RESP with rsp_data = selected lane (byte lane addr[1:0], half lane addr[1]), zero- or sign-extended per req_signed.
REQ-019 From RD, a sub-word store SHALL go to WR with mem_write_data = captured word, with only the addressed byte/half replaced by the low bits of wdata.
REQ-020 In WR, SHALL assert MemWrite=1 for exactly one cycle; a word store writes wdata unmodified; then go to RESP with rsp_data=0.
REQ-021 In RESP, SHALL hold rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE; there is no IDLE bypass, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-022 MemRead and MemWrite SHALL never both be 1; both are 0 outside RD/WR; mem_address stays stable for the whole request.
REQ-023 Latency from acceptance to rsp_valid: load 2 cycles, word store 2, sub-word store 3, misaligned 1.
REQ-024 rsp_err SHALL be 1 only for a trapped misaligned access; such a request performs no memory strobe and returns rsp_data=0.

Reset
REQ-025 While rst=0, SHALL force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, MemRead=0, MemWrite=0, mem_address=0, mem_write_data=0, asynchronously.
REQ-026 Reset asserted mid-request (RD/WR/RESP) SHALL abandon the request with no further strobe or response.
REQ-027 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned -> RESP with rsp_err=1 (REQ-024).
REQ-029 Macro undefined: no access is misaligned; offending low address bits are forced to 0 (half: addr[0], word: addr[1:0]) and the access proceeds normally; rsp_err stays 0.

Structure
REQ-030 Package lsu_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state typedef and WORD_OFFSET_W=2.
REQ-031 Combinational sub-module lsu_align SHALL perform lane extract/extend for loads and lane merge for stores; load_store_unit holds the FSM and registers.

Verification
REQ-032 Preset memory word 15=65: load word at addr 60 -> MemRead for 1 cycle at mem_address 15; rsp_valid 2 cycles after acceptance; rsp_data=65, rsp_err=0.
REQ-033 Word 10 = 0x11223344; store byte 0xAB at addr 41 -> RD then WR; mem_write_data=0x1122AB44 at mem_address 10; a following signed byte load at addr 41 -> rsp_data=0xFFFFFFAB.
REQ-034 Signed half load at addr 42 of word 0x80017FFF -> rsp_data=0xFFFF8001; unsigned -> 0x00008001.
REQ-035 With LSU_MISALIGN_TRAP_EN: word load at addr 62 -> no strobes, rsp_err=1, rsp_data=0 after 1 cycle; without the macro: same request reads word 15 -> rsp_data=65.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable and req_ready stays 0; with rst pulsed to 0 during WR, memory is unchanged and all outputs match REQ-025.
